icu_sequencer: RTL and testbench
================================

ICU_SEQUENCER -- requirements
Module: icu_sequencer

Interface
REQ-001 Parameter ADDR_W, default 8, SHALL set program address width and return-stack entry width.
REQ-002 Parameter STACK_DEPTH, default 4, SHALL set the number of return-stack entries; legal values are 2..16.
REQ-003 clk  input  1  SHALL be the system clock; all state updates on its rising edge.
REQ-004 rst  input  1  SHALL be the reset: asynchronous, active-high.
REQ-005 run  input  1  SHALL be level start/continue enable; sampled in IDLE and HALT.
REQ-006 prog_addr  output  ADDR_W  SHALL be the program memory read address (= PC).
REQ-007 prog_data  input  4+ADDR_W  SHALL be the program word: [ADDR_W+3:ADDR_W] opcode (instruction_t), [ADDR_W-1:0] operand, valid 1 cycle after prog_addr.
REQ-008 instruction  output  instruction_t  SHALL be the opcode presented to the ICU.
REQ-009 io_addr  output  ADDR_W  SHALL be the operand of the issued word, for the I/O select mux.
REQ-010 icu_req / icu_ack  output / input  1 / 1  SHALL be the 4-phase handshake to the ICU req_prev/ack_prev.
REQ-011 icu_jmp, icu_rtn, icu_flag_f  input  1 each  SHALL be the ICU jmp, rtn, flag_f outputs.
REQ-012 halted  output  1  SHALL be high in HALT state.
REQ-013 stack_err  output  1  SHALL be a sticky overflow/underflow flag.

Function
REQ-014 States: IDLE, FETCH, ISSUE, EXEC, RELEASE, HALT.
REQ-015 IDLE -> FETCH when run=1; PC unchanged.
REQ-016 FETCH: prog_addr=PC held one cycle; next cycle -> ISSUE, latching opcode into instruction and operand into io_addr.
REQ-017 ISSUE: icu_req=1 with instruction/io_addr stable; stays until icu_ack=1, then -> EXEC.
REQ-018 EXEC (one cycle, icu_req still 1): sample icu_jmp/icu_rtn/icu_flag_f; priority flag_f > rtn > jmp > sequential.
REQ-019 Sequential: PC <= PC+1 modulo 2^ADDR_W (all-ones wraps to 0).
REQ-020 jmp: push PC+1 (modulo) onto return stack, PC <= io_addr.
REQ-021 rtn: pop return stack into PC.
REQ-022 flag_f: PC <= PC+1, next state after RELEASE is HALT instead of FETCH.
REQ-023 RELEASE: icu_req=0; stays until icu_ack=0, then -> FETCH (or HALT; or IDLE if run=0).
REQ-024 With combinational ack (ack=req) each instruction SHALL take exactly 4 cycles: FETCH, ISSUE, EXEC, RELEASE.
REQ-025 Push when stack full: entry discarded, PC still loads io_addr, stack_err<=1.
REQ-026 Pop when stack empty: PC <= 0, stack_err<=1.
REQ-027 HALT -> FETCH when run transitions 0->1 (rising edge seen after halt); run held high does not restart.
REQ-028 instruction, io_addr SHALL not change while icu_req=1.
REQ-029 run deasserted mid-instruction SHALL take effect only at end of RELEASE; the handshake is never abandoned.

Reset
REQ-030 On rst: state IDLE, PC=0, stack empty, stack_err=0, icu_req=0, halted=0, instruction=NOPO, io_addr=0.
REQ-031 rst asserted mid-handshake SHALL drop icu_req immediately; the ICU is reset by the same rst.

Structure
REQ-032 Sequencer state enum and program-word field widths SHALL be added to the shared instructions package beside instruction_t.
REQ-033 Return stack SHALL be sub-module icu_ret_stack (push, pop, din, dout, full, empty; pointer-based, STACK_DEPTH entries).
REQ-034 No combinational path from icu_ack to icu_req.

Verification
REQ-035 Program 0:LD 5, 1:STO 6, 2:NOPO; run=1, ack=req -> prog_addr 0,1,2 at 4-cycle spacing, io_addr 5 then 6.
REQ-036 Word at 3: JMP 0x40, at 0x40: RTN -> PC 3, 0x40, 4; stack depth returns to 0, stack_err=0.
REQ-037 Five nested JMPs, STACK_DEPTH=4 -> fifth JMP still loads target, stack_err=1 and stays 1 until rst.
REQ-038 RTN with empty stack at PC 0x10 -> next fetch address 0, stack_err=1.
REQ-039 NOPF at 0x07 -> halted=1 after RELEASE, PC=0x08; run 1->0->1 -> fetch resumes at 0x08.
REQ-040 PC=0xFF sequential, then ack delayed 3 cycles in ISSUE -> req held 3 extra cycles, next fetch address 0x00; rst pulse in ISSUE -> req=0 same cycle, PC=0.

Source files
------------

// File: rtl/icu_sequencer_pkg.sv
// Shared instruction set for the ICU, plus the sequencer state encoding and
// program-word field widths.
package icu_sequencer_pkg;

    localparam int OPCODE_W = 4;

    typedef enum logic [OPCODE_W-1:0] {
        NOPO = 4'h0,
        LD   = 4'h1,
        LDC  = 4'h2,
        AND  = 4'h3,
        ANDC = 4'h4,
        OR   = 4'h5,
        ORC  = 4'h6,
        XNOR = 4'h7,
        STO  = 4'h8,
        STOC = 4'h9,
        IEN  = 4'hA,
        OEN  = 4'hB,
        JMP  = 4'hC,
        RTN  = 4'hD,
        SKZ  = 4'hE,
        NOPF = 4'hF
    } instruction_t;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_ISSUE,
        S_EXEC,
        S_RELEASE,
        S_HALT
    } seq_state_t;

    // Program word is {opcode, operand}; operand width follows the address width.
    function automatic int prog_word_w(input int addr_w);
        return OPCODE_W + addr_w;
    endfunction

endpackage

// File: rtl/icu_ret_stack.sv
// Pointer-based LIFO return stack for the ICU sequencer's JMP/RTN pairs.
module icu_ret_stack
    import icu_sequencer_pkg::*;
#(
    parameter int ADDR_W      = 8,
    parameter int STACK_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic              pop,
    input  logic [ADDR_W-1:0] din,
    output logic [ADDR_W-1:0] dout,
    output logic              full,
    output logic              empty
);

    localparam int PTR_W = $clog2(STACK_DEPTH + 1);
    localparam int IDX_W = $clog2(STACK_DEPTH);

    logic [ADDR_W-1:0] mem [STACK_DEPTH];
    logic [PTR_W-1:0]  ptr;
    logic [IDX_W-1:0]  wr_idx;
    logic [IDX_W-1:0]  top_idx;

    assign full    = (ptr == PTR_W'(STACK_DEPTH));
    assign empty   = (ptr == '0);
    assign wr_idx  = IDX_W'(ptr);
    assign top_idx = IDX_W'(ptr - PTR_W'(1));
    assign dout    = empty ? '0 : mem[top_idx];

    // ptr counts valid entries, so 0 = empty and STACK_DEPTH = full.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr <= '0;
        end else if (push && !full) begin
            ptr <= ptr + PTR_W'(1);
        end else if (pop && !empty) begin
            ptr <= ptr - PTR_W'(1);
        end
    end

    // NOTE: entries carry no reset; the pointer alone defines which are valid.
    always_ff @(posedge clk) begin
        if (push && !full) begin
            mem[wr_idx] <= din;
        end
    end

endmodule

// File: rtl/icu_sequencer.sv
// Instruction sequencer for the ICU: fetches program words, issues them over a
// 4-phase handshake and applies jump/return/halt outcomes to the PC.
module icu_sequencer
    import icu_sequencer_pkg::*;
#(
    parameter int ADDR_W      = 8,
    parameter int STACK_DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       run,
    output logic [ADDR_W-1:0]          prog_addr,
    input  logic [OPCODE_W+ADDR_W-1:0] prog_data,
    output instruction_t               instruction,
    output logic [ADDR_W-1:0]          io_addr,
    output logic                       icu_req,
    input  logic                       icu_ack,
    input  logic                       icu_jmp,
    input  logic                       icu_rtn,
    input  logic                       icu_flag_f,
    output logic                       halted,
    output logic                       stack_err
);

    seq_state_t        state, next_state;
    logic [ADDR_W-1:0] pc, pc_next, pc_inc;
    logic              halt_pend, halt_pend_next;
    logic              run_q;
    logic              load_word, err_set, push, pop;
    logic [ADDR_W-1:0] stack_dout;
    logic              stack_full, stack_empty;

    icu_ret_stack #(
        .ADDR_W      (ADDR_W),
        .STACK_DEPTH (STACK_DEPTH)
    ) u_ret_stack (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .din   (pc_inc),
        .dout  (stack_dout),
        .full  (stack_full),
        .empty (stack_empty)
    );

    assign pc_inc    = pc + ADDR_W'(1);
    assign prog_addr = pc;
    // Decoded from state only, so icu_ack never reaches icu_req combinationally.
    assign icu_req   = (state == S_ISSUE) || (state == S_EXEC);
    assign halted    = (state == S_HALT);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of the others.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= S_IDLE;
            pc          <= '0;
            instruction <= NOPO;
            io_addr     <= '0;
            stack_err   <= 1'b0;
            halt_pend   <= 1'b0;
            run_q       <= 1'b0;
        end else begin
            state     <= next_state;
            pc        <= pc_next;
            halt_pend <= halt_pend_next;
            run_q     <= run;
            if (err_set) begin
                stack_err <= 1'b1;
            end
            if (load_word) begin
                instruction <= instruction_t'(prog_data[ADDR_W+OPCODE_W-1:ADDR_W]);
                io_addr     <= prog_data[ADDR_W-1:0];
            end
        end
    end

    // NOTE: every output of this block is defaulted first so no path infers a latch.
    always_comb begin
        next_state     = state;
        pc_next        = pc;
        halt_pend_next = halt_pend;
        load_word      = 1'b0;
        err_set        = 1'b0;
        push           = 1'b0;
        pop            = 1'b0;
        unique case (state)
            S_IDLE:  if (run) next_state = S_FETCH;
            S_FETCH: begin
                load_word  = 1'b1;
                next_state = S_ISSUE;
            end
            S_ISSUE: if (icu_ack) next_state = S_EXEC;
            S_EXEC: begin
                next_state = S_RELEASE;
                if (icu_flag_f) begin
                    pc_next        = pc_inc;
                    halt_pend_next = 1'b1;
                end else if (icu_rtn) begin
                    if (stack_empty) begin
                        pc_next = '0;
                        err_set = 1'b1;
                    end else begin
                        pop     = 1'b1;
                        pc_next = stack_dout;
                    end
                end else if (icu_jmp) begin
                    push    = !stack_full;
                    err_set = stack_full;
                    pc_next = io_addr;
                end else begin
                    pc_next = pc_inc;
                end
            end
            S_RELEASE: begin
                if (!icu_ack) begin
                    halt_pend_next = 1'b0;
                    if (halt_pend)  next_state = S_HALT;
                    else if (!run)  next_state = S_IDLE;
                    else            next_state = S_FETCH;
                end
            end
            // A held-high run must not restart; only a fresh rising edge does.
            S_HALT:  if (run && !run_q) next_state = S_FETCH;
            default: next_state = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_icu_sequencer.sv
// Self-checking bench for icu_sequencer: directed scenarios plus a random
// program run, checked against an instruction-level reference model.
module tb_icu_sequencer;
    import icu_sequencer_pkg::*;

    localparam int ADDR_W = 8;
    localparam int DEPTH  = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic              run;
    logic [ADDR_W-1:0] prog_addr;
    logic [ADDR_W+3:0] prog_data;
    instruction_t      instruction;
    logic [ADDR_W-1:0] io_addr;
    logic              icu_req, icu_ack, icu_jmp, icu_rtn, icu_flag_f;
    logic              halted, stack_err;

    int checks = 0;
    int errors = 0;

    logic [ADDR_W+3:0] mem [256];
    int   cyc = 0;
    int   ack_delay = 0;
    logic ack_r;
    int   ack_cnt;

    // Reference model state: PC, return stack as a queue, sticky error, halt.
    int   m_pc;
    int   m_stack[$];
    bit   m_err;
    bit   m_halt;
    int   last_rise, spacing, req_len;

    icu_sequencer #(.ADDR_W(ADDR_W), .STACK_DEPTH(DEPTH)) dut (
        .clk        (clk),
        .rst        (rst),
        .run        (run),
        .prog_addr  (prog_addr),
        .prog_data  (prog_data),
        .instruction(instruction),
        .io_addr    (io_addr),
        .icu_req    (icu_req),
        .icu_ack    (icu_ack),
        .icu_jmp    (icu_jmp),
        .icu_rtn    (icu_rtn),
        .icu_flag_f (icu_flag_f),
        .halted     (halted),
        .stack_err  (stack_err)
    );

    always #5 clk = ~clk;

    // Synchronous program ROM: data valid the cycle after the address.
    always @(posedge clk) begin
        cyc       <= cyc + 1;
        prog_data <= mem[prog_addr];
    end

    // ICU stand-in: flags follow the issued opcode; ack either mirrors req or
    // rises ack_delay cycles late.
    assign icu_jmp    = icu_req && (instruction == JMP);
    assign icu_rtn    = icu_req && (instruction == RTN);
    assign icu_flag_f = icu_req && (instruction == NOPF);
    assign icu_ack    = (ack_delay == 0) ? icu_req : ack_r;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            ack_r   <= 1'b0;
            ack_cnt <= 0;
        end else if (!icu_req) begin
            ack_r   <= 1'b0;
            ack_cnt <= 0;
        end else if (ack_cnt >= ack_delay - 1) begin
            ack_r <= 1'b1;
        end else begin
            ack_cnt <= ack_cnt + 1;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    function automatic void model_reset();
        m_pc   = 0;
        m_stack.delete();
        m_err  = 1'b0;
        m_halt = 1'b0;
    endfunction

    // One instruction's effect on the PC, written from the instruction rules.
    function automatic void model_step(input instruction_t op, input int operand);
        case (op)
            NOPF: begin
                m_pc   = (m_pc + 1) % 256;
                m_halt = 1'b1;
            end
            RTN: begin
                if (m_stack.size() == 0) begin
                    m_pc  = 0;
                    m_err = 1'b1;
                end else begin
                    m_pc = m_stack.pop_back();
                end
            end
            JMP: begin
                if (m_stack.size() < DEPTH) m_stack.push_back((m_pc + 1) % 256);
                else                        m_err = 1'b1;
                m_pc = operand;
            end
            default: m_pc = (m_pc + 1) % 256;
        endcase
    endfunction

    task automatic do_reset();
        rst = 1'b1;
        ack_delay = 0;
        tick(2);
        rst = 1'b0;
        model_reset();
    endtask

    task automatic clear_mem();
        for (int i = 0; i < 256; i++) mem[i] = '0;
    endtask

    task automatic set_word(input int addr, input instruction_t op, input int operand);
        mem[addr] = {op, 8'(operand)};
    endtask

    // Follows one instruction from req rise through RELEASE and any halt.
    task automatic exec_one(input string tag);
        int           n;
        instruction_t op;
        logic [7:0]   opd;
        logic [11:0]  word;
        bit           stable;
        n = 0;
        while (icu_req !== 1'b1 && n < 40) begin
            tick(1);
            n++;
        end
        check({tag, "_req_rise"}, 32'(icu_req), 1);
        spacing   = cyc - last_rise;
        last_rise = cyc;
        word = mem[m_pc];
        op   = instruction_t'(word[11:8]);
        opd  = word[7:0];
        check({tag, "_fetch_addr"}, 32'(prog_addr), m_pc);
        check({tag, "_opcode"}, 32'(instruction), 32'(op));
        check({tag, "_io_addr"}, 32'(io_addr), 32'(opd));
        stable = 1'b1;
        n = 0;
        while (icu_req === 1'b1 && n < 40) begin
            tick(1);
            n++;
            if (icu_req === 1'b1 && (instruction !== op || io_addr !== opd)) stable = 1'b0;
        end
        req_len = n;
        check({tag, "_req_fall"}, 32'(icu_req), 0);
        check({tag, "_stable"}, 32'(stable), 1);
        model_step(op, int'(opd));
        check({tag, "_next_pc"}, 32'(prog_addr), m_pc);
        check({tag, "_stack_err"}, 32'(stack_err), 32'(m_err));
        if (m_halt) begin
            tick(4);
            check({tag, "_halted"}, 32'(halted), 1);
            check({tag, "_halt_pc"}, 32'(prog_addr), m_pc);
            run = 1'b0;
            tick(1);
            run = 1'b1;
            m_halt = 1'b0;
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        run = 1'b0;
        clear_mem();
        model_reset();
        last_rise = 0;
        tick(2);

        // Reset values, then IDLE holds with run low.
        check("rst_req", 32'(icu_req), 0);
        check("rst_halted", 32'(halted), 0);
        check("rst_stack_err", 32'(stack_err), 0);
        check("rst_instruction", 32'(instruction), 32'(NOPO));
        check("rst_io_addr", 32'(io_addr), 0);
        check("rst_pc", 32'(prog_addr), 0);
        rst = 1'b0;
        tick(3);
        check("idle_no_req", 32'(icu_req), 0);

        // Straight-line, call/return, then RTN on an empty stack at 0x10.
        set_word(8'h00, LD, 5);
        set_word(8'h01, STO, 6);
        set_word(8'h03, JMP, 8'h40);
        set_word(8'h40, RTN, 0);
        set_word(8'h10, RTN, 0);
        run = 1'b1;
        exec_one("seq0");
        for (int i = 1; i < 18; i++) begin
            exec_one($sformatf("seq%0d", i));
            check($sformatf("seq%0d_spacing", i), 32'(spacing), 4);
        end
        check("empty_rtn_pc", 32'(prog_addr), 0);
        check("empty_rtn_err", 32'(stack_err), 1);

        // Five nested jumps overflow a 4-deep stack; error is sticky until rst.
        do_reset();
        clear_mem();
        for (int i = 0; i < 4; i++) set_word(i, JMP, i + 1);
        set_word(4, JMP, 8'h20);
        set_word(8'h21, LD, 1);
        for (int i = 0; i < 5; i++) exec_one($sformatf("nest%0d", i));
        check("overflow_target", 32'(prog_addr), 8'h20);
        check("overflow_err", 32'(stack_err), 1);
        exec_one("nest_after0");
        exec_one("nest_after1");
        check("overflow_sticky", 32'(stack_err), 1);
        do_reset();
        check("overflow_cleared", 32'(stack_err), 0);

        // NOPF at 0x07 halts with PC 0x08; run 1->0->1 resumes there.
        clear_mem();
        set_word(8'h07, NOPF, 0);
        set_word(8'h08, LD, 3);
        for (int i = 0; i < 9; i++) exec_one($sformatf("halt%0d", i));

        // PC wrap at 0xFF with a slow ack, then reset during ISSUE.
        do_reset();
        clear_mem();
        set_word(8'h00, JMP, 8'hFF);
        exec_one("wrap_jmp");
        ack_delay = 3;
        exec_one("wrap_ff");
        check("slow_ack_req_len", 32'(req_len), 5);
        check("wrap_pc", 32'(prog_addr), 0);
        ack_delay = 0;
        exec_one("wrap_jmp2");
        begin
            int n;
            n = 0;
            while (icu_req !== 1'b1 && n < 40) begin
                tick(1);
                n++;
            end
            check("rst_issue_rise", 32'(icu_req), 1);
            check("rst_issue_pc_before", 32'(prog_addr), 8'hFF);
            rst = 1'b1;
            #1;
            check("rst_issue_req", 32'(icu_req), 0);
            check("rst_issue_pc", 32'(prog_addr), 0);
            tick(1);
            rst = 1'b0;
            model_reset();
        end

        // Random program with random ack latency.
        do_reset();
        for (int i = 0; i < 256; i++) mem[i] = 12'($urandom);
        for (int i = 0; i < 80; i++) begin
            ack_delay = $urandom_range(0, 3);
            exec_one($sformatf("rnd%0d", i));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
